// File: rtl/imem_program_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the
// program loader, bundled as one interface.
interface imem_program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset_hold;
    logic              done;
    logic              error;

    // Byte source / supervisor side.
    modport master (
        output rx_valid, rx_data, reload,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset_hold, done, error
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_data, reload,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset_hold, done, error
    );
endinterface

// File: rtl/imem_program_loader.sv
// Runtime boot loader: receives a length-prefixed byte stream, packs it into
// little-endian 32-bit words, writes them to instruction memory from address 0
// upward and holds the CPU in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the CPU is released.
module imem_program_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_program_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CHK;
    localparam logic [2:0] S_AFTER_ZERO = S_CHK;
`else
    localparam logic [2:0] S_AFTER_DATA = S_FLUSH;
    localparam logic [2:0] S_AFTER_ZERO = S_DONE;
`endif

    logic [2:0]        state;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;   // one extra bit so DEPTH itself is representable
    logic [LEN_W-1:0]  len;
    logic [23:0]       word_buf;   // bytes 0..2 of the word being assembled
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              xfer;
    logic [LEN_W-1:0]  len_full;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign len_full  = LEN_W'({bus.rx_data, len[7:0]});
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

    // Handshake readiness and boot status are pure functions of the state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus.rx_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: bus.rx_ready = 1'b1;
            default:                           bus.rx_ready = 1'b0;
        endcase
    end

    assign bus.done           = (state == S_DONE);
    assign bus.error          = (state == S_ERROR);
    assign bus.cpu_reset_hold = (state != S_DONE);
    assign bus.imem_we        = imem_we;
    assign bus.imem_addr      = imem_addr;
    assign bus.imem_wdata     = imem_wdata;

    // Stream parser, word packer and write-strobe generator.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state      <= S_LEN_LO;
            byte_idx   <= '0;
            word_idx   <= '0;
            len        <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            imem_we <= 1'b0;   // the write strobe is a single-cycle pulse
            case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len   <= LEN_W'(bus.rx_data);
                        state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len <= len_full;
                        if (len_full == '0)
                            state <= S_AFTER_ZERO;
                        else if (32'(len_full) > DEPTH)
                            state <= S_ERROR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc  <= chk_acc ^ bus.rx_data;
`endif
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= {bus.rx_data, word_buf};
                                word_idx   <= word_idx + 1'b1;
                                if (last_word)
                                    state <= S_AFTER_DATA;
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if (bus.rx_data != chk_acc)
                            state <= S_ERROR;
                        else if (len == '0)
                            state <= S_DONE;
                        else
                            state <= S_FLUSH;
                    end
                end
`endif
                S_FLUSH: state <= S_DONE;   // lets the final strobe finish before release
                S_DONE, S_ERROR: begin
                    if (bus.reload) begin
                        state    <= S_LEN_LO;
                        byte_idx <= '0;
                        word_idx <= '0;
                        len      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc  <= '0;
`endif
                    end
                end
                default: state <= S_LEN_LO;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed images, an expected
// write queue built from each image's bytes, and a per-cycle compare process.
module tb_imem_program_loader;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_program_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          cyc         = 0;
    int          last_we_cyc = -1;
    logic        prev_done   = 1'b0;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the expected-write queue and the status rules.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            check("hold_is_not_done", 32'(bus.cpu_reset_hold), 32'(!bus.done));
            if (bus.done || bus.error)
                check("ready_low_when_idle", 32'(bus.rx_ready), 32'd0);
            if (bus.imem_we) begin
                wlog_addr.push_back(32'(bus.imem_addr));
                wlog_data.push_back(bus.imem_wdata);
                check("hold_during_write", 32'(bus.cpu_reset_hold), 32'd1);
                check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("write_addr", 32'(bus.imem_addr), exp_addr_q.pop_front());
                    check("write_data", bus.imem_wdata, exp_data_q.pop_front());
                end
                last_we_cyc = cyc;
            end
            if (bus.done && !prev_done && last_we_cyc >= 0) begin
`ifdef LOADER_CHECKSUM_EN
                check("release_after_write", 32'(cyc > last_we_cyc), 32'd1);
`else
                check("release_timing", 32'(cyc), 32'(last_we_cyc + 1));
`endif
            end
            if ((bus.done && !prev_done) || bus.error)
                last_we_cyc = -1;
            prev_done = bus.done;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.rx_ready)
            check("handshake_timeout", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(bus.cpu_reset_hold), 32'd1);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
    endtask

    task automatic do_reload(input string tag);
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_hold"}, 32'(bus.cpu_reset_hold), 32'd1);
        check({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    // Sends a header of `len` words plus data_q, predicting writes and outcome
    // from the stream rules; lat returns cycles from last accepted byte to done/error.
    task automatic run_image(input string tag, input int len, input int gap_max,
                             input bit bad_chk, input bit junk, output int lat_o);
        logic [15:0] l;
        logic [7:0]  x;
        bit          exp_err;
        int          n;
        l = 16'(len);
        x = 8'h00;
        exp_err = (len > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < len; i++) begin
                exp_addr_q.push_back(32'(i));
                exp_data_q.push_back(32'(data_q[4*i]) | (32'(data_q[4*i+1]) << 8) |
                                     (32'(data_q[4*i+2]) << 16) | (32'(data_q[4*i+3]) << 24));
            end
            for (int i = 0; i < 4 * len; i++)
                x = x ^ data_q[i];
        end
        send_byte(l[7:0], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
        send_byte(l[15:8], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
        if (!exp_err) begin
            for (int i = 0; i < 4 * len; i++)
                send_byte(data_q[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (x ^ 8'h01) : x, 0);
            exp_err = bad_chk;
            if (junk)
                $display("note: %s trailing junk skipped, a byte here would be the checksum", tag);
`else
            if (bad_chk)
                $display("note: %s checksum disabled, bad_chk has no effect", tag);
            if (junk) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = 8'hEE;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                bus.rx_valid = 1'b0;
            end
`endif
        end
        n = 0;
        while (!(bus.done || bus.error) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat_o = n;
        check({tag, "_done"}, 32'(bus.done), 32'(!exp_err));
        check({tag, "_error"}, 32'(bus.error), 32'(exp_err));
        check({tag, "_hold"}, 32'(bus.cpu_reset_hold), 32'(exp_err));
        check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.reload   = 1'b0;
        reset        = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two-word image, back-to-back bytes (5th byte lands during the first strobe).
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_image("two_word", 2, 0, 1'b0, 1'b0, lat);
        check("two_word_lat", 32'(lat), 32'd1);
        check("two_word_count", 32'(wlog_data.size()), 32'd2);
        if (wlog_data.size() == 2) begin
            check("two_word_a0", wlog_addr[0], 32'd0);
            check("two_word_d0", wlog_data[0], 32'h0000_0013);
            check("two_word_a1", wlog_addr[1], 32'd1);
            check("two_word_d1", wlog_data[1], 32'h0010_0093);
        end

        // Zero-length image.
        do_reload("reload1");
        data_q.delete();
        run_image("zero_len", 0, 0, 1'b0, 1'b0, lat);
        check("zero_len_lat", 32'(lat), 32'd0);
        check("zero_len_count", 32'(wlog_data.size()), 32'd0);

        // Oversized length: 257 words with 256-word memory.
        do_reload("reload2");
        run_image("too_long", 257, 0, 1'b0, 1'b0, lat);
        check("too_long_lat", 32'(lat), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("too_long_sticky", 32'(bus.error), 32'd1);
        check("too_long_hold", 32'(bus.cpu_reset_hold), 32'd1);

        // One word with random gaps and trailing bytes that must be ignored.
        do_reload("reload3");
        data_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_image("gappy", 1, 3, 1'b0, 1'b1, lat);
        check("gappy_count", 32'(wlog_data.size()), 32'd1);
        if (wlog_data.size() == 1)
            check("gappy_d0", wlog_data[0], 32'h1234_5678);

        // Reset mid-image, then a clean one-word image.
        do_reload("reload4");
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        #2;
        check_reset_state("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        wlog_addr.delete();
        wlog_data.delete();
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image("after_reset", 1, 0, 1'b0, 1'b0, lat);
        check("after_reset_count", 32'(wlog_data.size()), 32'd1);
        if (wlog_data.size() == 1) begin
            check("after_reset_a0", wlog_addr[0], 32'd0);
            check("after_reset_d0", wlog_data[0], 32'hDDCC_BBAA);
        end

        // Full-capacity image: len == DEPTH is legal.
        do_reload("reload5");
        data_q.delete();
        for (int i = 0; i < 4 * DEPTH; i++)
            data_q.push_back(8'(i * 7 + 3));
        run_image("full", DEPTH, 0, 1'b0, 1'b0, lat);
        check("full_count", 32'(wlog_data.size()), 32'(DEPTH));
        if (wlog_data.size() == DEPTH)
            check("full_last_addr", wlog_addr[DEPTH-1], 32'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
        // Checksum accepted, then rejected.
        do_reload("reload6");
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_image("chk_good", 1, 0, 1'b0, 1'b0, lat);
        do_reload("reload7");
        run_image("chk_bad", 1, 0, 1'b1, 1'b0, lat);
        check("chk_bad_count", 32'(wlog_data.size()), 32'd1);
        if (wlog_data.size() == 1)
            check("chk_bad_d0", wlog_data[0], 32'h4433_2211);
`endif

        do_reload("reload_end");
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
